sbox_share_arbiter: RTL

Time-multiplexes one external 32-bit S-box slice (four parallel byte S-boxes, combinational) between two requesters. The round datapath requests SubBytes on a full 128-bit state. The key-expansion unit requests SubWord on a single 32-bit word. The block arbitrates between them, sequences the 128-bit state through the slice one word per cycle, and returns registered results with done pulses.

---
 rtl/sbox_share_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sbox_share_arbiter.sv
// Shares one combinational 32-bit S-box slice between a 128-bit SubBytes requester
// and a 32-bit SubWord requester; the state is streamed one word per cycle.
module sbox_share_arbiter #(
    parameter bit KS_PRIORITY = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req,
    input  logic [127:0] st_data,
    output logic         st_ack,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         ks_req,
    input  logic [31:0]  ks_word,
    output logic         ks_ack,
    output logic         ks_done,
    output logic [31:0]  ks_result,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_SUB = 2'd1,
        KS_SUB = 2'd2
    } state_t;

    state_t         state_r;
    logic [1:0]     idx_r;
    logic           rr_st_first_r;
    logic [95:0]    st_lat_r;
    logic [95:0]    acc_r;
    logic [127:0]   st_result_r;
    logic [31:0]    ks_result_r;
    logic [31:0]    sb_in_r;
    logic           st_done_r;
    logic           ks_done_r;
    logic           busy_r;
    logic           st_grant_s;
    logic           ks_grant_s;

    // Word 0 goes to the slice straight from the port; only words 1..3 are kept.
    function automatic logic [31:0] next_word(input logic [95:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[31:0];
            2'd1:    return w[63:32];
            2'd2:    return w[95:64];
            default: return 32'd0;
        endcase
    endfunction

    // Grant decision while idle; suppressed during reset so no handshake is lost.
    always_comb begin
        st_grant_s = 1'b0;
        ks_grant_s = 1'b0;
        if (!rst && state_r == IDLE) begin
            if (st_req && ks_req) begin
                if (KS_PRIORITY) begin
                    ks_grant_s = 1'b1;
                end else if (rr_st_first_r) begin
                    st_grant_s = 1'b1;
                end else begin
                    ks_grant_s = 1'b1;
                end
            end else if (st_req) begin
                st_grant_s = 1'b1;
            end else if (ks_req) begin
                ks_grant_s = 1'b1;
            end else begin
                st_grant_s = 1'b0;
                ks_grant_s = 1'b0;
            end
        end else begin
            st_grant_s = 1'b0;
            ks_grant_s = 1'b0;
        end
    end

    // Sequencer: latches the request, walks the slice, publishes results with done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            idx_r         <= 2'd0;
            rr_st_first_r <= 1'b1;
            st_lat_r      <= 96'd0;
            acc_r         <= 96'd0;
            st_result_r   <= 128'd0;
            ks_result_r   <= 32'd0;
            sb_in_r       <= 32'd0;
            st_done_r     <= 1'b0;
            ks_done_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            st_done_r <= 1'b0;
            ks_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (st_grant_s) begin
                        state_r       <= ST_SUB;
                        idx_r         <= 2'd0;
                        st_lat_r      <= st_data[127:32];
                        sb_in_r       <= st_data[31:0];
                        rr_st_first_r <= 1'b0;
                        busy_r        <= 1'b1;
                    end else if (ks_grant_s) begin
                        state_r       <= KS_SUB;
                        sb_in_r       <= ks_word;
                        rr_st_first_r <= 1'b1;
                        busy_r        <= 1'b1;
                    end else begin
                        sb_in_r <= 32'd0;
                    end
                end
                ST_SUB: begin
                    if (idx_r == 2'd3) begin
                        // Whole state lands at once, so a reset mid-op never leaves a partial result.
                        st_result_r <= {sb_out, acc_r};
                        st_done_r   <= 1'b1;
                        state_r     <= IDLE;
                        idx_r       <= 2'd0;
                        sb_in_r     <= 32'd0;
                        busy_r      <= 1'b0;
                    end else begin
                        acc_r[{idx_r, 5'd0} +: 32] <= sb_out;
                        sb_in_r <= next_word(st_lat_r, idx_r);
                        idx_r   <= idx_r + 2'd1;
                    end
                end
                KS_SUB: begin
                    ks_result_r <= sb_out;
                    ks_done_r   <= 1'b1;
                    state_r     <= IDLE;
                    sb_in_r     <= 32'd0;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= 2'd0;
                    sb_in_r <= 32'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign st_ack    = st_grant_s;
    assign ks_ack    = ks_grant_s;
    assign st_done   = st_done_r;
    assign ks_done   = ks_done_r;
    assign st_result = st_result_r;
    assign ks_result = ks_result_r;
    assign sb_in     = sb_in_r;
    assign busy      = busy_r;

endmodule
